scalar_warp_sequencer: RTL and testbench

SCALAR_WARP_SEQUENCER -- requirements
Module: scalar_warp_sequencer

---
 rtl/scalar_warp_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_scalar_warp_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_warp_sequencer.sv
// Scalar warp sequencer: single-issue FETCH..UPDATE control loop for one warp,
// with bounded waits on instruction fetch and LSU completion handshakes.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package scalar_warp_sequencer_pkg;
   typedef logic [7:0] instruction_memory_address_t;
   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      REQUEST,
      WAIT,
      EXECUTE,
      UPDATE,
      DONE
   } warp_state_t;
endpackage

module scalar_warp_sequencer
   import scalar_warp_sequencer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = `DATA_WIDTH,
   parameter int unsigned WAIT_TIMEOUT = 1024
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  instruction_memory_address_t start_pc,
   output logic                        fetch_req,
   input  logic                        fetch_valid,
   input  logic                        decoded_mem_read,
   input  logic                        decoded_mem_write,
   input  logic                        decoded_branch,
   input  logic                        decoded_ret,
   input  logic                        branch_taken,
   input  instruction_memory_address_t branch_target,
   output logic                        lsu_req,
   input  logic                        lsu_done,
   output warp_state_t                 warp_state,
   output logic                        warp_enable,
   output instruction_memory_address_t pc,
   output logic                        done,
   output logic                        timeout_err,
   output logic [DATA_WIDTH-1:0]       retired_count
);

   localparam int unsigned CNT_W = $clog2(WAIT_TIMEOUT + 1);

   warp_state_t                 r_state;
   warp_state_t                 w_next_state;
   instruction_memory_address_t r_pc;
   instruction_memory_address_t r_next_pc;
   logic [DATA_WIDTH-1:0]       r_retired;
   logic [CNT_W-1:0]            r_wait_cnt;
   logic                        r_mem_read;
   logic                        r_mem_write;
   logic                        r_branch;
   logic                        r_ret;
   logic                        r_timeout_err;

   logic w_mem_op;
   logic w_fetch_wait;
   logic w_lsu_wait;
   logic w_hs_absent;
   logic w_timeout;
   logic w_start_ok;
   logic w_enter_wait;

   assign w_mem_op     = r_mem_read | r_mem_write;
   assign w_fetch_wait = (r_state == FETCH) && !fetch_valid;
   assign w_lsu_wait   = (r_state == WAIT) && w_mem_op && !lsu_done;
   assign w_hs_absent  = w_fetch_wait | w_lsu_wait;
   // Timeout only fires when the handshake is still absent on the last allowed cycle.
   assign w_timeout    = w_hs_absent && (r_wait_cnt == CNT_W'(WAIT_TIMEOUT - 1));
   assign w_start_ok   = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_enter_wait = (w_next_state != r_state) &&
                         ((w_next_state == FETCH) || (w_next_state == WAIT));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE, DONE: begin
            if (start) w_next_state = FETCH;
         end
         FETCH: begin
            if (w_timeout)        w_next_state = DONE;
            else if (fetch_valid) w_next_state = DECODE;
         end
         DECODE:  w_next_state = REQUEST;
         REQUEST: w_next_state = WAIT;
         WAIT: begin
            if (w_timeout)                 w_next_state = DONE;
            else if (!w_mem_op || lsu_done) w_next_state = EXECUTE;
         end
         EXECUTE: w_next_state = UPDATE;
         UPDATE:  w_next_state = r_ret ? DONE : FETCH;
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      fetch_req   = 1'b0;
      lsu_req     = 1'b0;
      warp_enable = 1'b1;
      done        = 1'b0;
      case (r_state)
         IDLE:    warp_enable = 1'b0;
         DONE: begin
            warp_enable = 1'b0;
            done        = 1'b1;
         end
         FETCH:   fetch_req = 1'b1;
         WAIT:    lsu_req = w_mem_op && (r_wait_cnt == '0);
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wait_cnt <= '0;
      end else if (w_enter_wait) begin
         r_wait_cnt <= '0;
      end else if (w_hs_absent) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_branch    <= 1'b0;
         r_ret       <= 1'b0;
      end else if (r_state == DECODE) begin
         r_mem_read  <= decoded_mem_read;
         r_mem_write <= decoded_mem_write;
         r_branch    <= decoded_branch;
         r_ret       <= decoded_ret;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc          <= '0;
         r_next_pc     <= '0;
         r_retired     <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         if (w_start_ok) begin
            r_pc          <= start_pc;
            r_retired     <= '0;
            r_timeout_err <= 1'b0;
         end
         if (r_state == EXECUTE) begin
            r_next_pc <= (r_branch && branch_taken) ? branch_target
                                                    : r_pc + instruction_memory_address_t'(1);
         end
         if (r_state == UPDATE) begin
            r_pc      <= r_next_pc;
            r_retired <= r_retired + 1'b1;
         end
         if (w_timeout) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   assign warp_state    = r_state;
   assign pc            = r_pc;
   assign retired_count = r_retired;
   assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_scalar_warp_sequencer.sv
// Scoreboard bench for scalar_warp_sequencer: acts as fetch unit, decoder,
// branch unit and LSU, and checks per-instruction stage timing and results.
module tb_scalar_warp_sequencer;
   import scalar_warp_sequencer_pkg::*;

   localparam int unsigned DW = 16;
   localparam int unsigned WT = 8;

   logic                        clk = 1'b0;
   logic                        reset;
   logic                        start;
   instruction_memory_address_t start_pc;
   logic                        fetch_req;
   logic                        fetch_valid;
   logic                        decoded_mem_read;
   logic                        decoded_mem_write;
   logic                        decoded_branch;
   logic                        decoded_ret;
   logic                        branch_taken;
   instruction_memory_address_t branch_target;
   logic                        lsu_req;
   logic                        lsu_done;
   warp_state_t                 warp_state;
   logic                        warp_enable;
   instruction_memory_address_t pc;
   logic                        done;
   logic                        timeout_err;
   logic [DW-1:0]               retired_count;

   scalar_warp_sequencer #(
      .DATA_WIDTH  (DW),
      .WAIT_TIMEOUT(WT)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .start_pc         (start_pc),
      .fetch_req        (fetch_req),
      .fetch_valid      (fetch_valid),
      .decoded_mem_read (decoded_mem_read),
      .decoded_mem_write(decoded_mem_write),
      .decoded_branch   (decoded_branch),
      .decoded_ret      (decoded_ret),
      .branch_taken     (branch_taken),
      .branch_target    (branch_target),
      .lsu_req          (lsu_req),
      .lsu_done         (lsu_done),
      .warp_state       (warp_state),
      .warp_enable      (warp_enable),
      .pc               (pc),
      .done             (done),
      .timeout_err      (timeout_err),
      .retired_count    (retired_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]    pc;
      logic [DW-1:0] retired;
      warp_state_t   st;
      logic          terr;
   } exp_t;

   exp_t          sb_q[$];
   int            n_checks = 0;
   int            n_fail   = 0;
   logic [7:0]    m_pc;
   logic [DW-1:0] m_ret;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle_drives();
      fetch_valid = 1'b0;
      lsu_done    = 1'b0;
      {decoded_mem_read, decoded_mem_write, decoded_branch, decoded_ret} = 4'b0000;
      branch_taken  = 1'b0;
      branch_target = 8'h00;
   endtask

   task automatic do_start(input string name, input logic [7:0] spc);
      start    = 1'b1;
      start_pc = spc;
      @(negedge clk);
      start    = 1'b0;
      start_pc = 8'hEE;
      m_pc     = spc;
      m_ret    = '0;
      check({name, "_state"},   32'(warp_state),    32'(FETCH));
      check({name, "_pc"},      32'(pc),            32'(spc));
      check({name, "_retired"}, 32'(retired_count), 32'd0);
      check({name, "_terr"},    32'(timeout_err),   32'd0);
   endtask

   // Entered at a negedge with the DUT in FETCH; returns at the negedge after UPDATE
   // (or on reaching DONE through a timeout).
   task automatic run_instr(input string name, input bit rd, input bit wr, input bit br,
                            input bit rt, input bit tk, input logic [7:0] tgt,
                            input int fdly, input int ldly, input bit poke);
      exp_t        e;
      warp_state_t st;
      bit          memop = rd | wr;
      bit          f_to  = (fdly >= int'(WT));
      bit          w_to  = !f_to && memop && (ldly >= int'(WT));
      bit          fin   = 1'b0;
      int          fc = 0, dc = 0, rc = 0, wc = 0, ec = 0, uc = 0;
      int          lreq = 0, lreq_bad = 0, fr_bad = 0;

      if (f_to || w_to) begin
         e.pc = m_pc; e.retired = m_ret; e.st = DONE; e.terr = 1'b1;
      end else begin
         e.pc      = (br && tk) ? tgt : m_pc + 8'd1;
         e.retired = m_ret + 1'b1;
         e.st      = rt ? DONE : FETCH;
         e.terr    = 1'b0;
      end
      sb_q.push_back(e);

      for (int i = 0; i < 64 && !fin; i++) begin
         st          = warp_state;
         fetch_valid = 1'b0;
         lsu_done    = 1'b0;
         {decoded_mem_read, decoded_mem_write, decoded_branch, decoded_ret} = ~{rd, wr, br, rt};
         branch_taken  = !tk;
         branch_target = ~tgt;
         if ((st == FETCH) != (fetch_req == 1'b1)) fr_bad++;
         if (st != WAIT && lsu_req) lreq_bad++;
         case (st)
            FETCH: begin
               fetch_valid = (fc == fdly);
               if (poke && fc == 0) begin
                  start    = 1'b1;
                  start_pc = 8'h77;
               end
               fc++;
            end
            DECODE: begin
               {decoded_mem_read, decoded_mem_write, decoded_branch, decoded_ret} = {rd, wr, br, rt};
               lsu_done = 1'b1;
               dc++;
            end
            REQUEST: begin
               lsu_done = 1'b1;
               rc++;
            end
            WAIT: begin
               if (lsu_req) begin
                  lreq++;
                  if (wc != 0) lreq_bad++;
               end
               lsu_done = memop && (wc == ldly);
               wc++;
            end
            EXECUTE: begin
               branch_taken  = tk;
               branch_target = tgt;
               ec++;
            end
            UPDATE:  uc++;
            default: fin = 1'b1;
         endcase
         if (!fin) begin
            @(negedge clk);
            start = 1'b0;
            if (st == UPDATE) fin = 1'b1;
         end
      end
      idle_drives();

      check({name, "_bound"},    32'(fin),    32'd1);
      check({name, "_fetch_cyc"}, 32'(fc), f_to ? 32'(WT) : 32'(fdly + 1));
      check({name, "_fetch_req"}, 32'(fr_bad), 32'd0);
      if (!f_to) begin
         check({name, "_decode_cyc"},  32'(dc), 32'd1);
         check({name, "_request_cyc"}, 32'(rc), 32'd1);
         check({name, "_wait_cyc"}, 32'(wc),
               w_to ? 32'(WT) : (memop ? 32'(ldly + 1) : 32'd1));
         check({name, "_lsu_req_n"},   32'(lreq), memop ? 32'd1 : 32'd0);
         check({name, "_lsu_req_pos"}, 32'(lreq_bad), 32'd0);
         if (!w_to) begin
            check({name, "_exec_cyc"}, 32'(ec), 32'd1);
            check({name, "_upd_cyc"},  32'(uc), 32'd1);
         end
      end

      e = sb_q.pop_front();
      check({name, "_pc"},      32'(pc),            32'(e.pc));
      check({name, "_retired"}, 32'(retired_count), 32'(e.retired));
      check({name, "_state"},   32'(warp_state),    32'(e.st));
      check({name, "_terr"},    32'(timeout_err),   32'(e.terr));
      check({name, "_done"},    32'(done),          32'(e.st == DONE));
      m_pc  = e.pc;
      m_ret = e.retired;
   endtask

   task automatic hold_check(input string name, input logic terr);
      repeat (3) @(negedge clk);
      check({name, "_state"},   32'(warp_state),    32'(DONE));
      check({name, "_done"},    32'(done),          32'd1);
      check({name, "_enable"},  32'(warp_enable),   32'd0);
      check({name, "_pc"},      32'(pc),            32'(m_pc));
      check({name, "_retired"}, 32'(retired_count), 32'(m_ret));
      check({name, "_terr"},    32'(timeout_err),   32'(terr));
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      start_pc = 8'h00;
      idle_drives();
      #2;
      check("rst_state",   32'(warp_state),    32'(IDLE));
      check("rst_pc",      32'(pc),            32'd0);
      check("rst_retired", 32'(retired_count), 32'd0);
      check("rst_fetch",   32'(fetch_req),     32'd0);
      check("rst_lsu",     32'(lsu_req),       32'd0);
      check("rst_enable",  32'(warp_enable),   32'd0);
      check("rst_done",    32'(done),          32'd0);
      check("rst_terr",    32'(timeout_err),   32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_hold_state", 32'(warp_state), 32'(IDLE));

      do_start("A_start", 8'h05);
      run_instr("A_alu",   0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
      run_instr("A_load",  1, 0, 0, 0, 0, 8'h00, 0, 3, 0);
      run_instr("A_br_tk", 0, 0, 1, 0, 1, 8'h20, 0, 0, 0);
      run_instr("A_ret",   0, 0, 0, 1, 0, 8'h00, 0, 0, 0);
      hold_check("A_hold", 1'b0);

      do_start("B_start", 8'h00);
      run_instr("B_alu_poke", 0, 0, 0, 0, 0, 8'h00, 0, 0, 1);
      run_instr("B_store0",   0, 1, 0, 0, 0, 8'h00, 0, 0, 0);
      run_instr("B_br_nt",    0, 0, 1, 0, 0, 8'h30, 0, 0, 0);
      run_instr("B_ret",      0, 0, 0, 1, 0, 8'h00, 0, 0, 0);
      hold_check("B_hold", 1'b0);

      do_start("C_start", 8'h07);
      run_instr("C_br_nt",    0, 0, 1, 0, 0, 8'h20, 0, 0, 0);
      run_instr("C_load_ret", 1, 0, 0, 1, 0, 8'h00, 2, 7, 0);

      do_start("D_start", 8'hFF);
      run_instr("D_wrap",     0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
      run_instr("D_fetch_edge", 0, 0, 0, 1, 0, 8'h00, 7, 0, 0);

      do_start("E_start", 8'h40);
      run_instr("E_fetch_to", 0, 0, 0, 0, 0, 8'h00, 8, 0, 0);
      hold_check("E_hold", 1'b1);

      do_start("F_start", 8'h50);
      run_instr("F_alu",     0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
      run_instr("F_wait_to", 1, 0, 0, 0, 0, 8'h00, 0, 99, 0);
      hold_check("F_hold", 1'b1);

      do_start("R_start", 8'h10);
      fetch_valid = 1'b1;
      @(negedge clk);
      fetch_valid      = 1'b0;
      decoded_mem_read = 1'b1;
      @(negedge clk);
      decoded_mem_read = 1'b0;
      @(negedge clk);
      check("R_wait_state", 32'(warp_state), 32'(WAIT));
      check("R_wait_req",   32'(lsu_req),    32'd1);
      #2 reset = 1'b1;
      #1;
      check("R_async_state",   32'(warp_state),    32'(IDLE));
      check("R_async_lsu",     32'(lsu_req),       32'd0);
      check("R_async_pc",      32'(pc),            32'd0);
      check("R_async_retired", 32'(retired_count), 32'd0);
      check("R_async_enable",  32'(warp_enable),   32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("R_idle_state", 32'(warp_state), 32'(IDLE));
      check("R_idle_pc",    32'(pc),         32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
